// File: rtl/flp_defs.sv
// Shared definitions for the iterative floating-point divider: derived widths,
// controller states and the operand classification record.
package flp_defs;

  typedef enum logic [1:0] {IDLE, DIV, RND, OUT} state_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  function automatic int flp_fwidth(input int ew, input int sw);
    return 1 + ew + sw;
  endfunction

  function automatic int flp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Integer bit, stored bits, guard/round bits and one extra bit for the sticky.
  function automatic int flp_qw(input int sw, input int rsw);
    return sw + rsw + 2;
  endfunction

  localparam int FWIDTH = flp_fwidth(8, 23);
  localparam int BIAS   = flp_bias(8);
  localparam int QW     = flp_qw(23, 2);

endpackage

// File: rtl/flp_idiv.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first.
// done is high during the cycle whose closing edge produces the last bit.
module flp_idiv #(
  parameter int MW = 24,
  parameter int QW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [MW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quo,
  output logic          rem_nz
);

  localparam int CW = $clog2(QW);

  logic [MW:0]   rem;
  logic [MW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          ge;
  logic [MW-1:0] rem_sel;

  // rem always stays below 2*dvs, so the chosen partial remainder fits MW bits.
  always_comb begin
    ge      = (rem >= {1'b0, dvs});
    rem_sel = ge ? MW'(rem - {1'b0, dvs}) : rem[MW-1:0];
  end

  assign done   = busy && (cnt == '0);
  assign rem_nz = |rem;

  always_ff @(posedge clk) begin
    if (rst)        busy <= 1'b0;
    else if (start) busy <= 1'b1;
    else if (done)  busy <= 1'b0;
  end

  // NOTE: pure datapath registers carry no reset; busy alone qualifies them.
  always_ff @(posedge clk) begin
    if (start) begin
      rem <= {1'b0, dividend};
      dvs <= divisor;
      cnt <= CW'(QW - 1);
    end else if (busy) begin
      rem <= {rem_sel, 1'b0};
      quo <= {quo[QW-2:0], ge};
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/flp_div.sv
// Iterative IEEE-style floating-point divider with round-to-nearest-even,
// flush-to-zero for subnormals and a valid/ready handshake on each side.
module flp_div
  import flp_defs::*;
#(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EWIDTH+SWIDTH:0] i_a,
  input  logic [EWIDTH+SWIDTH:0] i_b,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [EWIDTH+SWIDTH:0] o_q,
  output logic                   o_valid,
  input  logic                   i_ready
);

  localparam int FW   = flp_fwidth(EWIDTH, SWIDTH);
  localparam int BS   = flp_bias(EWIDTH);
  localparam int QWL  = flp_qw(SWIDTH, RSWIDTH);
  localparam int EXW  = EWIDTH + 2;
  localparam int EMAX = (1 << EWIDTH) - 1;

  state_t state;

  // Unpack
  logic [EWIDTH-1:0] ea, eb;
  logic [SWIDTH-1:0] fa, fb;
  cls_t              cls_a, cls_b;

  always_comb begin
    ea         = i_a[FW-2 -: EWIDTH];
    eb         = i_b[FW-2 -: EWIDTH];
    fa         = i_a[SWIDTH-1:0];
    fb         = i_b[SWIDTH-1:0];
    cls_a.nan  = (&ea) && (|fa);
    cls_a.inf  = (&ea) && !(|fa);
    cls_a.zero = (ea == '0);
    cls_b.nan  = (&eb) && (|fb);
    cls_b.inf  = (&eb) && !(|fb);
    cls_b.zero = (eb == '0);
  end

  logic                  accept;
  logic                  sign_r;
  logic signed [EXW-1:0] exp_r;
  cls_t                  cls_a_r, cls_b_r;

  assign accept = (state == IDLE) && i_valid;

  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r  <= i_a[FW-1] ^ i_b[FW-1];
      exp_r   <= {2'b00, ea} - {2'b00, eb} + EXW'(BS);
      cls_a_r <= cls_a;
      cls_b_r <= cls_b;
    end
  end

  logic           div_done;
  logic [QWL-1:0] quo;
  logic           rem_nz;

  // The hidden bit is forced on even for zero/subnormal operands, so the divisor is never zero.
  flp_idiv #(.MW(SWIDTH + 1), .QW(QWL)) u_idiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend ({1'b1, fa}),
    .divisor  ({1'b1, fb}),
    .done     (div_done),
    .quo      (quo),
    .rem_nz   (rem_nz)
  );

  // Round and pack
  logic [QWL-2:0]        norm;
  logic [RSWIDTH:0]      low;
  logic                  round_up;
  logic [SWIDTH:0]       frac_sum;
  logic signed [EXW-1:0] exp_f;
  logic [FW-1:0]         result;

  always_comb begin
    norm     = quo[QWL-1] ? quo[QWL-2:0] : {quo[QWL-3:0], 1'b0};
    low      = {norm[RSWIDTH:1], norm[0] | rem_nz};
    round_up = low[RSWIDTH] & ((|low[RSWIDTH-1:0]) | norm[RSWIDTH+1]);
    frac_sum = {1'b0, norm[QWL-2 -: SWIDTH]} + (SWIDTH+1)'(round_up);
    exp_f    = exp_r - EXW'(!quo[QWL-1]) + EXW'(frac_sum[SWIDTH]);
    if (cls_a_r.nan || cls_b_r.nan || (cls_a_r.zero && cls_b_r.zero) ||
        (cls_a_r.inf && cls_b_r.inf))
      result = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
    else if (cls_a_r.inf || cls_b_r.zero || int'(exp_f) >= EMAX)
      result = {sign_r, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
    else if (cls_a_r.zero || cls_b_r.inf || int'(exp_f) <= 0)
      result = {sign_r, {(FW-1){1'b0}}};
    else
      result = {sign_r, exp_f[EWIDTH-1:0], frac_sum[SWIDTH-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_q     <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          state   <= DIV;
          o_ready <= 1'b0;
        end
        DIV: if (div_done) state <= RND;
        RND: begin
          o_q     <= result;
          o_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: if (i_ready) begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flp_div.sv
// Self-checking bench for flp_div at default widths: directed corner cases,
// handshake/reset behaviour and random operands against an exact-arithmetic model.
module tb_flp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_a, i_b;
  logic        i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [31:0] o_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flp_div dut (
    .clk     (clk),
    .rst     (rst),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_q     (o_q),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Correctly rounded single-precision quotient from exact integer division.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, sh;
    bit     s, an, ai, az, bn, bi, bz;
    longint ma, mb, num, q, r, sig, low, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    if (an || bn || (az && bz) || (ai && bi)) return 32'h7FC00000;
    if (ai || bz) return {s, 8'hFF, 23'd0};
    if (az || bi) return {s, 31'd0};
    ma  = longint'(a[22:0]) + (longint'(1) << 23);
    mb  = longint'(b[22:0]) + (longint'(1) << 23);
    num = ma << 26;
    q   = num / mb;
    r   = num % mb;
    e   = ea - eb + 127;
    if (q >= (longint'(1) << 26)) sh = 3;
    else begin
      sh = 2;
      e--;
    end
    sig  = q >> sh;
    low  = q & ((longint'(1) << sh) - 1);
    half = longint'(1) << (sh - 1);
    if (low > half || (low == half && (r != 0 || (sig % 2) == 1))) sig++;
    if (sig == (longint'(1) << 24)) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), 23'(sig)};
  endfunction

  // One full transaction: accept, latency, result, optional OUT hold, consume.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                        input string tag, input int hold, input bit poke);
    int n;
    @(negedge clk);
    check(32'(o_ready), 32'd1, {tag, " ready_idle"});
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (o_valid) break;
      if (poke && n == 3) begin
        check(32'(o_ready), 32'd0, {tag, " ready_div"});
        i_a     = 32'h3F800000;
        i_b     = 32'h3F800000;
        i_valid = 1'b1;
      end
      if (poke && n == 6) i_valid = 1'b0;
    end
    if (!o_valid) begin
      check(32'(o_valid), 32'd1, {tag, " timeout"});
      return;
    end
    check(32'(n), 32'd28, {tag, " latency"});
    check(o_q, exp_q, tag);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check(o_q, exp_q, {tag, " hold_q"});
      check(32'({o_valid, o_ready}), 32'd2, {tag, " hold_flags"});
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    check(32'({o_valid, o_ready}), 32'd1, {tag, " consumed"});
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    bit          rose;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check(32'({o_valid, o_ready}), 32'd1, "reset_flags");
    check(o_q, 32'd0, "reset_q");
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, "six_by_two", 0, 0);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "one_third", 0, 0);
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, "pos_div0", 0, 0);
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, "neg_div0", 0, 0);
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_zero", 0, 0);
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_inf", 0, 0);
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, "overflow", 0, 0);
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, "underflow", 0, 0);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in", 0, 0);
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, "subnormal_in", 0, 0);
    run_op(32'hC1200000, 32'h40A00000, 32'hC0000000, "hold_out", 5, 0);
    run_op(32'h40E00000, 32'h40000000, 32'h40600000, "busy_ignore", 0, 1);

    // Abort mid-division.
    @(negedge clk);
    i_a     = 32'h40C00000;
    i_b     = 32'h40000000;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(32'({o_valid, o_ready}), 32'd1, "abort_flags");
    @(negedge clk);
    rst  = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (o_valid) rose = 1'b1;
    end
    check(32'(rose), 32'd0, "abort_no_valid");
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, "after_abort", 0, 0);

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        a = $urandom;
        b = $urandom;
      end else begin
        a = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)};
        b = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)};
      end
      run_op(a, b, model(a, b), $sformatf("rand%0d_%h_%h", i, a, b), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
